// File: rtl/i2s_adc_rx.sv
// i2s_adc_rx: I2S receive deserializer for the WM8731 ADC path.
// Oversamples BCLK/ADCLRC/ADCDAT on clk, assembles {left,right} sample pairs
// and presents them on a valid/ready interface.
// Optional macro I2S_RX_FIFO_EN: buffer pairs in a FIFO_DEPTH-entry FIFO;
// otherwise a single output register pair holds one capture.
module i2s_adc_rx #(
  parameter int unsigned DW         = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i2s_bclk,
  input  logic          i2s_adclrc,
  input  logic          i2s_adcdat,
  input  logic          rx_ready,
  input  logic          ovf_clr,
  output logic          rx_valid,
  output logic [DW-1:0] rx_ldat,
  output logic [DW-1:0] rx_rdat,
  output logic          rx_ovf,
  output logic          frame_err
);

  localparam int unsigned CW = $clog2(DW + 1);

  typedef enum logic [2:0] {
    StSync,
    StLShift,
    StLWait,
    StRShift,
    StRWait
  } state_e;

  // [0]=sync1, [1]=sync2, [2]=edge-detect delay flop
  logic [2:0] bclk_sync;
  logic [1:0] lrc_sync;
  logic [1:0] dat_sync;
  // Registered bit strobe plus the LRC/data values that go with it
  logic       be_q;
  logic       lrc_q;
  logic       dat_q;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            lrc_prev_q, lrc_prev_d;
  logic [DW-1:0]   sh_l_q, sh_l_d;
  logic [DW-1:0]   sh_r_q, sh_r_d;
  logic            push_q, push_d;
  logic            ferr_q, ferr_d;
  logic            lrc_rise, lrc_fall;
  logic            ovf_set;
  logic            pop;

  // Synchronize the codec lines and register the BCLK rising-edge strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bclk_sync <= '0;
      lrc_sync  <= '0;
      dat_sync  <= '0;
      be_q      <= 1'b0;
      lrc_q     <= 1'b0;
      dat_q     <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[1:0], i2s_bclk};
      lrc_sync  <= {lrc_sync[0], i2s_adclrc};
      dat_sync  <= {dat_sync[0], i2s_adcdat};
      be_q      <= bclk_sync[1] & ~bclk_sync[2];
      lrc_q     <= lrc_sync[1];
      dat_q     <= dat_sync[1];
    end
  end

  assign lrc_rise = lrc_q & ~lrc_prev_q;
  assign lrc_fall = ~lrc_q & lrc_prev_q;

  // Frame FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StSync;
      cnt_q      <= '0;
      lrc_prev_q <= 1'b0;
      sh_l_q     <= '0;
      sh_r_q     <= '0;
      push_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lrc_prev_q <= lrc_prev_d;
      sh_l_q     <= sh_l_d;
      sh_r_q     <= sh_r_d;
      push_q     <= push_d;
      ferr_q     <= ferr_d;
    end
  end

  // Frame FSM next state: one step per sampled BCLK edge
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lrc_prev_d = lrc_prev_q;
    sh_l_d     = sh_l_q;
    sh_r_d     = sh_r_q;
    push_d     = 1'b0;
    ferr_d     = 1'b0;
    if (be_q) begin
      lrc_prev_d = lrc_q;
      unique case (state_q)
        StSync: begin
          if (lrc_fall) begin
            state_d = StLShift;
            cnt_d   = '0;
          end
        end
        StLShift: begin
          sh_l_d = {sh_l_q[DW-2:0], dat_q};
          cnt_d  = cnt_q + CW'(1);
          // With exactly DW BCLKs per channel the LSB edge also carries the LRC change
          if (cnt_q == CW'(DW - 1)) begin
            state_d = lrc_rise ? StRShift : StLWait;
            if (lrc_rise) cnt_d = '0;
          end else if (lrc_rise) begin
            ferr_d  = 1'b1;
            state_d = StSync;
          end
        end
        StLWait: begin
          if (lrc_rise) begin
            state_d = StRShift;
            cnt_d   = '0;
          end
        end
        StRShift: begin
          sh_r_d = {sh_r_q[DW-2:0], dat_q};
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(DW - 1)) begin
            push_d  = 1'b1;
            state_d = lrc_fall ? StLShift : StRWait;
            if (lrc_fall) cnt_d = '0;
          end else if (lrc_fall) begin
            ferr_d  = 1'b1;
            state_d = StLShift;
            cnt_d   = '0;
          end
        end
        StRWait: begin
          if (lrc_fall) begin
            state_d = StLShift;
            cnt_d   = '0;
          end
        end
        default: state_d = StSync;
      endcase
    end
  end

  assign frame_err = ferr_q;
  assign pop       = rx_valid & rx_ready;

`ifdef I2S_RX_FIFO_EN
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [DW-1:0] mem_l [FIFO_DEPTH];
  logic [DW-1:0] mem_r [FIFO_DEPTH];
  logic [AW:0]   wptr_q, rptr_q;
  logic          empty, full, accept;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  // A pop frees a slot in the same cycle, so push-on-full with pop is accepted
  assign accept  = push_q & (~full | pop);
  assign ovf_set = push_q & full & ~pop;

  // Pair FIFO storage and pointers; sh_l/sh_r stay stable one cycle past the push strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_l[i] <= '0;
        mem_r[i] <= '0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (accept) begin
        mem_l[wptr_q[AW-1:0]] <= sh_l_q;
        mem_r[wptr_q[AW-1:0]] <= sh_r_q;
        wptr_q                <= wptr_q + (AW+1)'(1);
      end
      if (pop) rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  assign rx_valid = ~empty;
  assign rx_ldat  = mem_l[rptr_q[AW-1:0]];
  assign rx_rdat  = mem_r[rptr_q[AW-1:0]];
`else
  logic          valid_q;
  logic [DW-1:0] ldat_q, rdat_q;
  logic          accept;
  logic          unused_cfg;

  assign unused_cfg = ^FIFO_DEPTH;
  assign accept     = push_q & (~valid_q | pop);
  assign ovf_set    = push_q & valid_q & ~pop;

  // Single output register pair
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      ldat_q  <= '0;
      rdat_q  <= '0;
    end else begin
      if (accept) begin
        valid_q <= 1'b1;
        ldat_q  <= sh_l_q;
        rdat_q  <= sh_r_q;
      end else if (pop) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_valid = valid_q;
  assign rx_ldat  = ldat_q;
  assign rx_rdat  = rdat_q;
`endif

  // Sticky overflow; a set in the same cycle as a clear wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ovf <= 1'b0;
    end else if (ovf_set) begin
      rx_ovf <= 1'b1;
    end else if (ovf_clr) begin
      rx_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_adc_rx.sv
// tb_i2s_adc_rx: randomized I2S stream generator with a queue-based pair model.
`timescale 1ns/1ps
module tb_i2s_adc_rx;

  localparam int DW         = 16;
  localparam int FIFO_DEPTH = 4;
`ifdef I2S_RX_FIFO_EN
  localparam int CAP = FIFO_DEPTH;
`else
  localparam int CAP = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bclk = 1'b0;
  logic          lrc = 1'b1;
  logic          dat = 1'b0;
  logic          ready = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          rx_valid;
  logic [DW-1:0] rx_ldat;
  logic [DW-1:0] rx_rdat;
  logic          rx_ovf;
  logic          frame_err;

  i2s_adc_rx #(.DW(DW), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .i2s_bclk  (bclk),
    .i2s_adclrc(lrc),
    .i2s_adcdat(dat),
    .rx_ready  (ready),
    .ovf_clr   (ovf_clr),
    .rx_valid  (rx_valid),
    .rx_ldat   (rx_ldat),
    .rx_rdat   (rx_rdat),
    .rx_ovf    (rx_ovf),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  // Model state: pairs still owed to the consumer, in order
  logic [2*DW-1:0] exp_q[$];
  logic            model_ovf = 1'b0;
  int              fe_count = 0;
  int              pop_count = 0;
  int              valid_cycles = 0;
  int              valid_rise_cyc = -1;
  int              lsb_cyc = 0;
  logic            prev_fe = 1'b0;
  logic            prev_valid = 1'b0;
  logic [DW-1:0]   last_l = '0;
  logic [DW-1:0]   last_r = '0;
  logic            rand_ready = 1'b0;

  // Stream generator state
  int              half = 4;
  int              bpc = 32;
  logic            carry = 1'b0;
  int              pend_cnt = 0;
  logic [2*DW-1:0] pend_pair = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_push(input logic [2*DW-1:0] p);
    if (exp_q.size() >= CAP) model_ovf = 1'b1;
    else exp_q.push_back(p);
  endtask

  // One BCLK period; data lags LRC by one slot as in I2S
  task automatic slot(input logic l, input logic b);
    bclk  = 1'b0;
    lrc   = l;
    dat   = carry;
    carry = b;
    tick(half);
    bclk = 1'b1;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        lsb_cyc = cyc;
        model_push(pend_pair);
      end
    end
    tick(half);
  endtask

  task automatic channel(input logic l, input logic [31:0] w, input int n);
    for (int j = 0; j < n; j++) slot(l, w[31-j]);
  endtask

  task automatic send_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
    logic [15:0] pad;
    pad = 16'($urandom);
    channel(1'b0, {l, pad}, bpc);
    pend_pair = {l, r};
    pend_cnt  = DW + 1;
    pad = 16'($urandom);
    channel(1'b1, {r, pad}, bpc);
  endtask

  task automatic clear_model();
    exp_q.delete();
    model_ovf = 1'b0;
    pend_cnt  = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_model();
    tick(3);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic drain();
    ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0 && !rx_valid) break;
      tick(1);
    end
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_valid_low", rx_valid, 0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) ready = ($urandom_range(0, 3) != 0);
  end

  // Compare process: every valid cycle, DUT head must equal the model's oldest pair
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (frame_err) begin
        fe_count++;
        check("frame_err_width", prev_fe, 0);
      end
      if (rx_valid) begin
        if (!prev_valid && valid_rise_cyc < 0) valid_rise_cyc = cyc;
        valid_cycles++;
        check("pair_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          check("rx_ldat", rx_ldat, exp_q[0][2*DW-1:DW]);
          check("rx_rdat", rx_rdat, exp_q[0][DW-1:0]);
          if (ready) begin
            last_l = rx_ldat;
            last_r = rx_rdat;
            pop_count++;
            void'(exp_q.pop_front());
          end
        end
      end
    end
    prev_fe    = frame_err;
    prev_valid = rx_valid;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0, pc0;

    // Reset state
    tick(3);
    check("reset_valid", rx_valid, 0);
    check("reset_ldat", rx_ldat, 0);
    check("reset_rdat", rx_rdat, 0);
    check("reset_ovf", rx_ovf, 0);
    check("reset_frame_err", frame_err, 0);
    rst = 1'b0;
    tick(2);

    // Basic pair at 8x, 32 BCLK per channel
    half = 4; bpc = 32; ready = 1'b1;
    do_reset();
    valid_rise_cyc = -1; valid_cycles = 0; fe0 = fe_count;
    channel(1'b1, $urandom, bpc);
    send_pair(16'h1234, 16'hABCD);
    channel(1'b0, $urandom, 2);
    tick(20);
    check("basic_valid_cycles", valid_cycles, 1);
    check("basic_latency", valid_rise_cyc - lsb_cyc, 5);
    check("basic_ldat", last_l, 16'h1234);
    check("basic_rdat", last_r, 16'hABCD);
    check("basic_frame_err", fe_count - fe0, 0);
    check("basic_ovf", rx_ovf, 0);
    drain();

    // Backpressure: 6 pairs with rx_ready low
    do_reset();
    ready = 1'b0;
    channel(1'b1, $urandom, bpc);
    for (int k = 1; k <= 6; k++) begin
      send_pair(16'(k), 16'(16'h8000 | k));
      check("bp_ovf_after_pair", rx_ovf, model_ovf);
    end
    channel(1'b0, $urandom, 2);
    check("bp_ovf_set", rx_ovf, 1);
    pc0 = pop_count;
    drain();
    check("bp_pairs_retained", pop_count - pc0, CAP);
    check("bp_last_ldat", last_l, CAP);
    check("bp_last_rdat", last_r, 16'h8000 | CAP);
    check("bp_ovf_sticky", rx_ovf, 1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("bp_ovf_cleared", rx_ovf, 0);

    // Short right channel
    do_reset();
    ready = 1'b1; fe0 = fe_count; pc0 = pop_count;
    channel(1'b1, $urandom, bpc);
    channel(1'b0, $urandom, bpc);
    channel(1'b1, $urandom, 10);
    send_pair(16'h5555, 16'hAAAA);
    channel(1'b0, $urandom, 2);
    tick(10);
    check("short_frame_err", fe_count - fe0, 1);
    check("short_pairs", pop_count - pc0, 1);
    check("short_ldat", last_l, 16'h5555);
    check("short_rdat", last_r, 16'hAAAA);
    drain();

    // Reset released mid right word
    rst = 1'b1;
    clear_model();
    fe0 = fe_count; pc0 = pop_count;
    channel(1'b1, $urandom, 5);
    rst = 1'b0;
    channel(1'b1, $urandom, bpc - 5);
    send_pair(16'($urandom), 16'($urandom));
    channel(1'b0, $urandom, 2);
    drain();
    check("rstart_pairs", pop_count - pc0, 1);
    check("rstart_frame_err", fe_count - fe0, 0);

    // Reset mid-frame with a pair held
    do_reset();
    ready = 1'b0;
    channel(1'b1, $urandom, bpc);
    send_pair(16'($urandom), 16'($urandom));
    channel(1'b0, $urandom, 8);
    check("midrst_held_valid", rx_valid, 1);
    rst = 1'b1;
    clear_model();
    #1;
    check("midrst_valid", rx_valid, 0);
    check("midrst_ldat", rx_ldat, 0);
    check("midrst_rdat", rx_rdat, 0);
    tick(2);
    rst = 1'b0;
    ready = 1'b1;
    fe0 = fe_count;
    channel(1'b0, $urandom, bpc - 8);
    channel(1'b1, $urandom, bpc);
    send_pair(16'h0F0F, 16'hF0F0);
    channel(1'b0, $urandom, 2);
    tick(10);
    check("midrst_ldat_after", last_l, 16'h0F0F);
    check("midrst_rdat_after", last_r, 16'hF0F0);
    check("midrst_frame_err", fe_count - fe0, 0);
    drain();

    // Minimum ratio: 4x, 16 BCLK per channel, 100 random pairs
    half = 2; bpc = 16;
    do_reset();
    fe0 = fe_count; pc0 = pop_count;
    rand_ready = 1'b1;
    channel(1'b1, $urandom, bpc);
    for (int k = 0; k < 100; k++) send_pair(16'($urandom), 16'($urandom));
    channel(1'b0, $urandom, 2);
    tick(20);
    rand_ready = 1'b0;
    tick(1);
    drain();
    check("minratio_pairs", pop_count - pc0, 100);
    check("minratio_frame_err", fe_count - fe0, 0);
    check("minratio_ovf", rx_ovf, model_ovf);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_adc_rx.md
# i2s_adc_rx

Receive-side I2S deserializer for the WM8731 ADC path. It runs on the I2S system clock and oversamples the codec-facing BCLK, ADCLRC and ADCDAT lines, which are driven by the I2S master. It assembles left/right sample pairs and presents them on a valid/ready interface, buffered for downstream consumers such as a loopback-to-DAC path or a capture RAM. It is the counterpart of the existing DAC serializer and fills the ADC ports that the I2S top currently leaves unused.

## Interface
- DW, 16, sample width per channel (bits kept, MSB-first).
- FIFO_DEPTH, 4, pair FIFO depth; must be a power of two and at least 2. Only used with `I2S_RX_FIFO_EN`.

Ports:
- clk  in  1  I2S system clock; all logic on the rising edge. Must run at least 4× the BCLK frequency.
- rst  in  1  asynchronous, active-high reset.
- i2s_bclk  in  1  bit clock, treated as asynchronous data.
- i2s_adclrc  in  1  frame clock, asynchronous; 0 = left, 1 = right.
- i2s_adcdat  in  1  serial ADC data, asynchronous.
- rx_ready  in  1  consumer accepts the pair when `rx_valid && rx_ready`.
- ovf_clr  in  1  single-cycle clear of `rx_ovf`.
- rx_valid  out  1  a pair is available.
- rx_ldat  out  DW  left sample.
- rx_rdat  out  DW  right sample.
- rx_ovf  out  1  sticky overflow flag.
- frame_err  out  1  one-cycle pulse when a short channel is detected.

Reset values: `rx_valid`=0, `rx_ldat`=0, `rx_rdat`=0, `rx_ovf`=0, `frame_err`=0. The FSM resets to SYNC, and the FIFO resets to empty.

## Operation
- Input conditioning:
  - Each of bclk, adclrc and adcdat passes through a 2-flop synchronizer.
  - A third bclk flop gives rising-edge detect `be` (sync2=1, sync3=0).
  - Data and LRC are sampled only when `be` is high, using their sync2 values.
- I2S format:
  - An LRC change is seen at BCLK edge k.
  - Edges k+1 .. k+DW carry MSB..LSB of the new channel.
  - Bits after the DW-th are ignored, so 32-BCLK channels are legal.
- FSM states:
  - SYNC: wait for LRC 1→0, then go to LSHIFT with bitcnt=0. Any other activity is ignored, so capture always starts on a left channel.
  - LSHIFT: shift the left bits in; when bitcnt reaches DW, go to LWAIT.
  - LWAIT: ignore bits; on LRC 0→1 go to RSHIFT.
  - RSHIFT: shift the right bits in; when bitcnt reaches DW, push {L,R} and go to RWAIT.
  - RWAIT: on LRC 1→0 go to LSHIFT.
- Short channel: an LRC change while in LSHIFT or RSHIFT before DW bits are in causes:
  - `frame_err` pulses;
  - the partial pair is discarded;
  - LSHIFT→SYNC (LRC 0→1 during left); RSHIFT→LSHIFT (LRC 1→0 during right).
- Push on full: the pair is dropped and `rx_ovf` is set.
  - A push and a pop in the same cycle on a full buffer: the push is accepted and there is no overflow.
  - If `ovf_clr` and a set occur in the same cycle, set wins.
- Reset mid-frame: all state clears immediately. Capture resumes only at the next LRC 1→0.

## Timing
- Let t be the clk edge on which the right LSB's BCLK rising edge is first registered by sync1.
  - `be` is high during the cycle after edge t+2.
  - The bit is shifted at edge t+3.
  - The pair is written at edge t+4.
  - `rx_valid` is high after edge t+4 when the buffer was empty.
- Pop: data changes or `rx_valid` falls on the clk edge where `rx_valid && rx_ready`.
- Output data is registered, with no combinational path from the inputs to the outputs.
- `frame_err` is high for exactly one cycle: the cycle after the edge on which the offending LRC change was registered.

## Configuration
- `I2S_RX_FIFO_EN` defined: a FIFO_DEPTH-entry FIFO of 2·DW-bit pairs. `rx_valid` = not empty, and outputs show the head entry.
- Not defined: a single output register pair. A capture while `rx_valid && !rx_ready` is dropped and sets `rx_ovf`. A capture in the same cycle as a pop is accepted. FIFO_DEPTH is ignored.

## Test plan
- Basic pair: clk = 8× BCLK, 32 BCLK per channel, send L=0x1234 and R=0xABCD with `rx_ready`=1. Expect:
  - `rx_valid` for 1 cycle with `rx_ldat`=0x1234 and `rx_rdat`=0xABCD, 4 clk after the right LSB edge;
  - `frame_err`=0 and `rx_ovf`=0.
- Backpressure: `rx_ready`=0, send 6 pairs 0x0001/0x8001 .. 0x0006/0x8006. Expect:
  - with FIFO (depth 4), pairs 1–4 retained and `rx_ovf`=1 after pair 5; draining gives 1,2,3,4;
  - without FIFO, pair 1 retained and `rx_ovf`=1;
  - `ovf_clr` returns `rx_ovf` to 0.
- Short frame: the right channel has only 10 bits before LRC 1→0. Expect a `frame_err` pulse, no push, and the next full pair 0x5555/0xAAAA delivered correctly.
- Start in right channel: release reset while LRC=1 mid-word. Expect no output until the first complete left+right pair after LRC 1→0.
- Reset mid-frame: assert `rst` during the left bit 7. Expect `rx_valid`=0 and outputs 0 immediately; after release, the next full pair 0x0F0F/0xF0F0 delivered.
- Minimum ratio: clk = 4× BCLK, 16 BCLK per channel (DW=16). Expect all 100 random pairs bit-exact with no `frame_err`.
